// File: rtl/mfhwt_pkg.sv
// Shared types for the 2x2 downscale controller: FSM states, RGB565 pixel
// type and the bit offsets of each pixel inside the 64-bit averager block word.
package mfhwt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVEN  = 2'd1,
    ODD   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef logic [15:0] rgb565_t;

  localparam int unsigned OFS_TL = 48;
  localparam int unsigned OFS_TR = 32;
  localparam int unsigned OFS_BL = 16;
  localparam int unsigned OFS_BR = 0;

endpackage

// File: rtl/mfhwt_linebuf.sv
// Line buffer holding one even row as packed pixel pairs {even, odd}.
// One write port, one registered read port; storage is not reset.
module mfhwt_linebuf #(
  parameter int unsigned DEPTH = 160,
  parameter int unsigned AW    = 8
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iWe,
  input  logic [AW-1:0] iWaddr,
  input  logic [31:0]   iWdata,
  input  logic          iRe,
  input  logic [AW-1:0] iRaddr,
  output logic [31:0]   oRdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Write port
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem_q[iWaddr] <= iWdata;
    end
  end

  // Registered read; the word is held until the next read enable
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rdata_q <= 32'h0000_0000;
    end else if (iRe) begin
      rdata_q <= mem_q[iRaddr];
    end
  end

  assign oRdata = rdata_q;

endmodule

// File: rtl/mfhwt_scale_ctrl.sv
// Sequences one 2x2-average downscale pass over a raster RGB565 frame.
// Optional sticky error flag for pixels pushed after a frame: MFHWT_SCALE_CTRL_ERR_EN.
module mfhwt_scale_ctrl
  import mfhwt_pkg::*;
#(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240,
  parameter int unsigned XW    = 9,
  parameter int unsigned YW    = 8
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iStart,
  input  logic          iPix_valid,
  input  logic [15:0]   iPix,
  output logic          oPix_ready,
  output logic [63:0]   oAvg_data,
  output logic          oAvg_valid,
  input  logic [15:0]   iAvg_result,
  output logic          oPix_valid,
  output logic [15:0]   oPix,
  output logic [XW-2:0] oX,
  output logic [YW-2:0] oY,
  output logic          oBusy,
  output logic          oDone
`ifdef MFHWT_SCALE_CTRL_ERR_EN
  ,
  output logic          oErr
`endif
);

  localparam int unsigned AW = XW - 1;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  rgb565_t         hold_q, hold_d;
  logic            ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic            avg_valid_q, avg_valid_d, pix_valid_q, pix_valid_d;
  logic [63:0]     avg_data_q, avg_data_d;
  logic [XW-2:0]   ox_q, ox_d;
  logic [YW-2:0]   oy_q, oy_d;
  logic            accept_s, start_s, lb_we_s, lb_re_s;
  logic [31:0]     lb_rdata_s;

  assign accept_s = iPix_valid && ready_q;
  assign start_s  = (state_q == IDLE) && iStart && !done_q;

  mfhwt_linebuf #(.DEPTH(IMG_W / 2), .AW(AW)) u_linebuf (
    .iClk    (iClk),
    .iReset_n(iReset_n),
    .iWe     (lb_we_s),
    .iWaddr  (x_q[XW-1:1]),
    .iWdata  ({hold_q, iPix}),
    .iRe     (lb_re_s),
    .iRaddr  (x_q[XW-1:1]),
    .oRdata  (lb_rdata_s)
  );

  // Frame sequencing, block assembly and output coordinate tracking
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    avg_valid_d = 1'b0;
    avg_data_d  = avg_data_q;
    pix_valid_d = avg_valid_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    lb_we_s     = 1'b0;
    lb_re_s     = 1'b0;

    if (pix_valid_q) begin
      if (ox_q == (XW-1)'(IMG_W / 2 - 1)) begin
        ox_d = '0;
        oy_d = (oy_q == (YW-1)'(IMG_H / 2 - 1)) ? '0 : oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end else begin
      ox_d = ox_q;
    end

    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = EVEN;
          x_d     = '0;
          y_d     = '0;
          ox_d    = '0;
          oy_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      EVEN: begin
        if (accept_s) begin
          if (!x_q[0]) begin
            hold_d = iPix;
          end else begin
            lb_we_s = 1'b1;
          end
          if (x_q == XW'(IMG_W - 1)) begin
            x_d     = '0;
            y_d     = y_q + 1'b1;
            state_d = ODD;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          state_d = EVEN;
        end
      end
      ODD: begin
        if (accept_s) begin
          if (!x_q[0]) begin
            hold_d  = iPix;
            lb_re_s = 1'b1;
          end else begin
            avg_valid_d               = 1'b1;
            avg_data_d[OFS_TL +: 16]  = lb_rdata_s[31:16];
            avg_data_d[OFS_TR +: 16]  = lb_rdata_s[15:0];
            avg_data_d[OFS_BL +: 16]  = hold_q;
            avg_data_d[OFS_BR +: 16]  = iPix;
          end
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            if (y_q == YW'(IMG_H - 1)) begin
              state_d = DRAIN;
            end else begin
              state_d = EVEN;
              y_d     = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          state_d = ODD;
        end
      end
      DRAIN: begin
        // In DRAIN the only result still in flight is the frame's last one
        if (pix_valid_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == EVEN) || (state_d == ODD);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      hold_q      <= 16'h0000;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_data_q  <= 64'h0;
      pix_valid_q <= 1'b0;
      ox_q        <= '0;
      oy_q        <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      avg_valid_q <= avg_valid_d;
      avg_data_q  <= avg_data_d;
      pix_valid_q <= pix_valid_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
    end
  end

  assign oPix_ready = ready_q;
  assign oAvg_valid = avg_valid_q;
  assign oAvg_data  = avg_data_q;
  assign oPix_valid = pix_valid_q;
  // The averager result is only valid in the oPix_valid cycle, so it is gated rather than re-registered
  assign oPix       = pix_valid_q ? iAvg_result : 16'h0000;
  assign oX         = ox_q;
  assign oY         = oy_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;

`ifdef MFHWT_SCALE_CTRL_ERR_EN
  logic err_q, err_d, hist_q, hist_d;

  // Sticky flag for pixels offered once a started frame has stopped accepting
  always_comb begin
    err_d  = err_q;
    hist_d = hist_q;
    if (start_s) begin
      err_d  = 1'b0;
      hist_d = 1'b1;
    end else if (iPix_valid && !ready_q &&
                 ((state_q == DRAIN) || ((state_q == IDLE) && hist_q))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag registers
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      err_q  <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      hist_q <= hist_d;
    end
  end

  assign oErr = err_q;
`endif

endmodule

// File: tb/tb_mfhwt_scale_ctrl.sv
// Directed bench for mfhwt_scale_ctrl on a 4x4 frame with a behavioural
// averager and a block/pixel scoreboard built from the input image.
module tb_mfhwt_scale_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int XW = 2;
  localparam int YW = 2;

  logic          iClk = 1'b0;
  logic          iReset_n = 1'b0;
  logic          iStart = 1'b0;
  logic          iPix_valid = 1'b0;
  logic [15:0]   iPix = 16'h0000;
  logic [15:0]   avg_res = 16'h0000;
  logic          oPix_ready, oAvg_valid, oPix_valid, oBusy, oDone;
  logic [63:0]   oAvg_data;
  logic [15:0]   oPix;
  logic [XW-2:0] oX;
  logic [YW-2:0] oY;
`ifdef MFHWT_SCALE_CTRL_ERR_EN
  logic          oErr;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_n = 0;
  int last_pix_cyc = 0;
  int done_cnt = 0;

  logic [15:0] img [H][W];
  logic [63:0] exp_blk[$];
  logic [15:0] exp_pix[$];
  int          exp_x[$], exp_y[$];
  int          stamp_a[$], stamp_p[$];
  logic [63:0] seen_blk[$];
  logic [15:0] seen_pix[$];
  logic [15:0] ref_pix[$];

  mfhwt_scale_ctrl #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .iStart     (iStart),
    .iPix_valid (iPix_valid),
    .iPix       (iPix),
    .oPix_ready (oPix_ready),
    .oAvg_data  (oAvg_data),
    .oAvg_valid (oAvg_valid),
    .iAvg_result(avg_res),
    .oPix_valid (oPix_valid),
    .oPix       (oPix),
    .oX         (oX),
    .oY         (oY),
    .oBusy      (oBusy),
    .oDone      (oDone)
`ifdef MFHWT_SCALE_CTRL_ERR_EN
    ,
    .oErr       (oErr)
`endif
  );

  always #5 iClk = ~iClk;

  function automatic logic [15:0] avg_px(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
    int r, g, bb;
    r  = (int'(a[15:11]) + int'(b[15:11]) + int'(c[15:11]) + int'(d[15:11])) / 4;
    g  = (int'(a[10:5])  + int'(b[10:5])  + int'(c[10:5])  + int'(d[10:5]))  / 4;
    bb = (int'(a[4:0])   + int'(b[4:0])   + int'(c[4:0])   + int'(d[4:0]))   / 4;
    return {r[4:0], g[5:0], bb[4:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // External averager: registered, result one cycle after the block
  always @(posedge iClk) begin
    if (oAvg_valid) avg_res <= avg_px(oAvg_data[63:48], oAvg_data[47:32], oAvg_data[31:16], oAvg_data[15:0]);
  end

  // Acceptance monitor: time-stamps every pixel that completes a 2x2 block
  always @(posedge iClk) begin
    cyc <= cyc + 1;
    if (!iReset_n) begin
      acc_n <= 0;
      stamp_a.delete();
      stamp_p.delete();
    end else if (iPix_valid && oPix_ready) begin
      if (((acc_n / W) % 2 == 1) && ((acc_n % W) % 2 == 1)) begin
        stamp_a.push_back(cyc);
        stamp_p.push_back(cyc);
      end
      acc_n <= (acc_n + 1) % (W * H);
    end
  end

  // Compare process: every meaningful output cycle against the model
  always @(negedge iClk) begin
    if (iReset_n) begin
      if (oAvg_valid) begin
        if (exp_blk.size() == 0 || stamp_a.size() == 0) begin
          check("avg_unexpected", 64'(oAvg_valid), 64'h0);
        end else begin
          seen_blk.push_back(oAvg_data);
          check("avg_data", oAvg_data, exp_blk.pop_front());
          check("avg_latency", 64'(cyc), 64'(stamp_a.pop_front() + 1));
        end
      end
      if (oPix_valid) begin
        if (exp_pix.size() == 0 || stamp_p.size() == 0) begin
          check("pix_unexpected", 64'(oPix_valid), 64'h0);
        end else begin
          seen_pix.push_back(oPix);
          check("pix_data", 64'(oPix), 64'(exp_pix.pop_front()));
          check("pix_x", 64'(oX), 64'(exp_x.pop_front()));
          check("pix_y", 64'(oY), 64'(exp_y.pop_front()));
          check("pix_latency", 64'(cyc), 64'(stamp_p.pop_front() + 2));
        end
        last_pix_cyc = cyc;
      end
      if (oDone) begin
        done_cnt++;
        check("done_latency", 64'(cyc), 64'(last_pix_cyc + 1));
        check("done_busy_low", 64'(oBusy), 64'h0);
        check("done_all_out", 64'(exp_pix.size()), 64'h0);
      end
    end
  end

  task automatic build_expect();
    for (int by = 0; by < H / 2; by++) begin
      for (int bx = 0; bx < W / 2; bx++) begin
        logic [15:0] tl, tr, bl, br;
        tl = img[2*by][2*bx];
        tr = img[2*by][2*bx+1];
        bl = img[2*by+1][2*bx];
        br = img[2*by+1][2*bx+1];
        exp_blk.push_back({tl, tr, bl, br});
        exp_pix.push_back(avg_px(tl, tr, bl, br));
        exp_x.push_back(bx);
        exp_y.push_back(by);
      end
    end
    seen_blk.delete();
    seen_pix.delete();
  endtask

  task automatic set_distinct();
    logic [15:0] v [16];
    v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888,
          16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'h1234, 16'h5678};
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v[r*W+c];
  endtask

  task automatic drive_frame(input bit gaps, input int stop_after, input int start_at, input bit push_tail);
    int n = 0;
    int k = 0;
    bit tog = 1'b1;
    @(negedge iClk);
    iStart = 1'b1;
    while (n < stop_after && k < 200) begin
      @(negedge iClk);
      k++;
      iStart = (n == start_at);
      if (oPix_ready && (!gaps || tog)) begin
        iPix_valid = 1'b1;
        iPix = img[n / W][n % W];
        n++;
      end else begin
        iPix_valid = 1'b0;
        iPix = 16'hDEAD;
      end
      tog = !tog;
    end
    @(negedge iClk);
    iStart = 1'b0;
    iPix_valid = push_tail;
    iPix = 16'hBEEF;
    @(negedge iClk);
    iPix_valid = 1'b0;
    if (n < stop_after) check("drive_timeout", 64'(n), 64'(stop_after));
  endtask

  task automatic wait_done();
    int k = 0;
    while (!oDone && k < 60) begin
      @(negedge iClk);
      k++;
    end
    if (!oDone) begin
      check("done_timeout", 64'(oDone), 64'h1);
    end else begin
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      check("start_in_done_ignored", 64'(oBusy), 64'h0);
      check("ready_low_idle", 64'(oPix_ready), 64'h0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(oPix_ready), 64'h0);
    check({tag, "_avg_valid"}, 64'(oAvg_valid), 64'h0);
    check({tag, "_avg_data"}, oAvg_data, 64'h0);
    check({tag, "_pix_valid"}, 64'(oPix_valid), 64'h0);
    check({tag, "_pix"}, 64'(oPix), 64'h0);
    check({tag, "_x"}, 64'(oX), 64'h0);
    check({tag, "_y"}, 64'(oY), 64'h0);
    check({tag, "_busy"}, 64'(oBusy), 64'h0);
    check({tag, "_done"}, 64'(oDone), 64'h0);
`ifdef MFHWT_SCALE_CTRL_ERR_EN
    check({tag, "_err"}, 64'(oErr), 64'h0);
`endif
  endtask

  initial begin
    int d0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge iClk);
    iReset_n = 1'b1;

    // All-white frame
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 16'hFFFF;
    build_expect();
    drive_frame(1'b0, W * H, -1, 1'b0);
    wait_done();
    check("white_count", 64'(seen_pix.size()), 64'd4);
    foreach (seen_pix[i]) check("white_literal", 64'(seen_pix[i]), 64'hFFFF);
    check("white_done_once", 64'(done_cnt), 64'd1);

    // Red/black stripes
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r % 2 == 0) ? 16'hF800 : 16'h0000;
    build_expect();
    drive_frame(1'b0, W * H, -1, 1'b0);
    wait_done();
    check("stripe_count", 64'(seen_pix.size()), 64'd4);
    foreach (seen_pix[i]) check("stripe_literal", 64'(seen_pix[i]), 64'h7800);

    // Distinct pixels, gap-free then with valid toggling every cycle
    set_distinct();
    build_expect();
    drive_frame(1'b0, W * H, -1, 1'b0);
    wait_done();
    check("blk0_literal", seen_blk.size() > 0 ? seen_blk[0] : 64'h0, 64'h1111_2222_5555_6666);
    check("blk1_literal", seen_blk.size() > 1 ? seen_blk[1] : 64'h0, 64'h3333_4444_7777_8888);
    ref_pix = seen_pix;
    build_expect();
    drive_frame(1'b1, W * H, -1, 1'b0);
    wait_done();
    check("gap_blk_count", 64'(seen_blk.size()), 64'd4);
    check("gap_same_order", 64'(seen_pix == ref_pix), 64'h1);

    // Mid-frame iStart ignored; pixel pushed during DRAIN
    build_expect();
    drive_frame(1'b0, W * H, 6, 1'b1);
    wait_done();
    check("midstart_count", 64'(seen_pix.size()), 64'd4);
`ifdef MFHWT_SCALE_CTRL_ERR_EN
    check("err_set", 64'(oErr), 64'h1);
    repeat (3) @(negedge iClk);
    check("err_sticky", 64'(oErr), 64'h1);
`endif

    // Reset in the middle of row 3
    build_expect();
    drive_frame(1'b0, 13, -1, 1'b0);
`ifdef MFHWT_SCALE_CTRL_ERR_EN
    check("err_cleared_by_start", 64'(oErr), 64'h0);
`endif
    d0 = done_cnt;
    #2 iReset_n = 1'b0;
    #1 check_zero("abort");
    repeat (3) @(negedge iClk);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    exp_blk.delete();
    exp_pix.delete();
    exp_x.delete();
    exp_y.delete();
    #2 iReset_n = 1'b1;

    // Full frame after abort
    build_expect();
    drive_frame(1'b0, W * H, -1, 1'b0);
    wait_done();
    check("after_abort_count", 64'(seen_pix.size()), 64'd4);
    check("after_abort_same", 64'(seen_pix == ref_pix), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mfhwt_scale_ctrl.md
Name: mfhwt_scale_ctrl

Overview:
- Sequences one 2x2-average downscale pass over a streamed RGB565 frame.
- Buffers each even row in a line buffer. On each odd row it assembles 2x2 pixel blocks into 64-bit words, feeds them to the four-pixel averager (mfhwt_avg, 1-cycle registered), and collects the averaged pixel.
- Emits a half-width, half-height stream with output coordinates and a frame-done pulse.
- Sits between the camera/frame-buffer reader and the next detection-pyramid stage.

Parameters:
- IMG_W, 320, input width in pixels; must be even and >= 2.
- IMG_H, 240, input height in rows; must be even and >= 2.
- XW, 9, input column counter width; must satisfy 2^XW >= IMG_W.
- YW, 8, input row counter width; must satisfy 2^YW >= IMG_H.

Ports:
- iClk  in  1  clock.
- iReset_n  in  1  asynchronous active-low reset.
- iStart  in  1  one-cycle pulse; begins a frame when idle.
- iPix_valid  in  1  input pixel valid.
- iPix  in  16  input RGB565 pixel, raster order.
- oPix_ready  out  1  controller accepts pixels; a transfer occurs when iPix_valid and oPix_ready are both high.
- oAvg_data  out  64  block word to the averager, ordered {TL, TR, BL, BR}, TL in [63:48].
- oAvg_valid  out  1  oAvg_data is a new block.
- iAvg_result  in  16  averager output; valid exactly 1 cycle after oAvg_valid.
- oPix_valid  out  1  downscaled pixel valid.
- oPix  out  16  downscaled pixel.
- oX  out  XW-1  output column, 0..IMG_W/2-1.
- oY  out  YW-1  output row, 0..IMG_H/2-1.
- oBusy  out  1  a frame is in progress.
- oDone  out  1  one-cycle pulse after the last output pixel.

Behaviour:
- Reset (asynchronous, active-low): state IDLE. All outputs and counters clear to 0: oPix_ready, oAvg_valid, oAvg_data, oPix_valid, oPix, oX, oY, oBusy, oDone. Line buffer contents are not cleared.
- States:
  - IDLE: on iStart go to EVEN. Set oBusy=1 and oPix_ready=1; clear x and y.
  - EVEN: accepted pixel at even x goes to hold register. At odd x, write {hold, iPix} to line buffer address x>>1. At x=IMG_W-1, go to ODD with y+1.
  - ODD:
    - Even x: hold the pixel and issue a line-buffer read at x>>1 (1-cycle registered read; result held until the next even-x acceptance).
    - Odd x, accepted in cycle t: at t+1, oAvg_valid=1 and oAvg_data={buf[31:16], buf[15:0], hold, iPix}.
    - At x=IMG_W-1: if y=IMG_H-1, go to DRAIN; otherwise go to EVEN with y+1.
  - DRAIN: oPix_ready=0. Wait for the final result, pulse oDone, return to IDLE. oBusy falls in the same cycle as the oDone pulse.
- oAvg_valid is a single-cycle pulse per block. Gaps in iPix_valid insert bubbles but never reorder data.
- Output path: at t+2, oPix_valid=1 and oPix=iAvg_result sampled at t+2. oX and oY give that pixel's coordinates; oX wraps to 0 after IMG_W/2-1 and oY then increments.
- oDone asserts the cycle after the last oPix_valid.
- oPix_ready is 0 in IDLE and DRAIN. iPix_valid while not ready is ignored and nothing is stored.
- iStart while oBusy=1 is ignored. iStart in the same cycle oDone pulses is ignored; it must be reissued.
- No downstream backpressure: the consumer must always accept oPix_valid.
- Reset mid-frame: aborts immediately with no oDone. The next iStart restarts at x=0, y=0.

Optional Feature:
- Macro MFHWT_SCALE_CTRL_ERR_EN.
- Defined: adds port oErr (out, 1 bit), reset 0. oErr goes sticky-high when iPix_valid=1 while oPix_ready=0 in DRAIN or IDLE with oBusy history (i.e. pixels pushed after the frame ended). It clears only on reset or iStart.
- Undefined: no oErr port and no extra logic; behaviour is otherwise identical.

Decomposition:
- Package mfhwt_pkg: state enum (IDLE, EVEN, ODD, DRAIN), RGB565 pixel typedef, and block-word field offsets (TL=48, TR=32, BL=16, BR=0).
- Sub-module mfhwt_linebuf: simple dual-port RAM, IMG_W/2 x 32 bits, registered read, one write port.

Test Plan:
- IMG_W=4, IMG_H=4, all pixels 16'hFFFF -> 4 outputs of 16'hFFFF at (0,0),(1,0),(0,1),(1,1); oDone pulses once, 1 cycle after the 4th output.
- Rows 0 and 2 = 16'hF800, rows 1 and 3 = 16'h0000 -> each output 16'h7800 (RSum=62, bits[6:2]=15).
- Row 0 pixels A,B,C,D and row 1 pixels E,F,G,H (distinct) -> first oAvg_data={A,B,E,F}, second {C,D,G,H}. oAvg_valid lands 1 cycle and oPix_valid 2 cycles after the odd-x acceptance.
- iPix_valid toggling 1/0 every cycle across the frame -> same output values and order as the gap-free run; no extra oAvg_valid pulses.
- iStart pulsed mid-frame -> ignored. iReset_n asserted mid-row-3 -> all outputs 0 immediately, no oDone. A new iStart then produces a correct full frame.
- With MFHWT_SCALE_CTRL_ERR_EN: pixel pushed during DRAIN -> oErr=1 and stays 1. Next iStart -> oErr=0.
